// File: rtl/pid_frame_scheduler.sv
// pid_frame_scheduler: one shared MAC datapath evaluating NCH PID loops per sample tick
module pid_frame_scheduler #(
    parameter int NCH = 4,
    parameter int WIDTH = 16,
    parameter int QBITS = 8,
    parameter logic signed [WIDTH-1:0] KP = 'h100,
    parameter logic signed [WIDTH-1:0] KI = 'h0,
    parameter logic signed [WIDTH-1:0] KD = 'h0,
    parameter int TICK_DIV = 1000
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst,
    input  logic                                   i_enable,
    input  logic                                   i_clear_int,
    input  logic [NCH*WIDTH-1:0]                   i_setpoint,
    input  logic [NCH*WIDTH-1:0]                   i_curpoint,
    output logic [NCH*WIDTH-1:0]                   o_out,
    output logic                                   o_valid,
    output logic                                   o_busy,
    output logic [(NCH > 1 ? $clog2(NCH) : 1)-1:0] o_ch,
    output logic                                   o_overrun
);
    localparam int CW = NCH > 1 ? $clog2(NCH) : 1;
    localparam int TW = $clog2(TICK_DIV);
    localparam int AW = 2 * WIDTH + 2;
    localparam logic [CW-1:0] LAST = CW'(NCH - 1);
    localparam logic [TW-1:0] TLAST = TW'(TICK_DIV - 1);
    localparam logic signed [AW-1:0] MAXV = {{(AW - WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
    localparam logic signed [AW-1:0] MINV = ~MAXV;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] FETCH = 3'd1;
    localparam logic [2:0] MUL_P = 3'd2;
    localparam logic [2:0] MUL_I = 3'd3;
    localparam logic [2:0] MUL_D = 3'd4;
    localparam logic [2:0] WRITE = 3'd5;

    function automatic logic signed [WIDTH-1:0] sat(input logic signed [AW-1:0] x);
        return x > MAXV ? MAXV[WIDTH-1:0] : x < MINV ? MINV[WIDTH-1:0] : x[WIDTH-1:0];
    endfunction

    logic [2:0]              state;
    logic [CW-1:0]           ch;
    logic [TW-1:0]           cnt;
    logic signed [AW-1:0]    acc;
    logic signed [WIDTH-1:0] err_r, integ_n_r;
    logic signed [WIDTH-1:0] integ [NCH];
    logic signed [WIDTH-1:0] prev_err [NCH];
    logic signed [WIDTH-1:0] sp_c, pv_c, err_c, integ_n_c, derr_c, op_a, op_b;
    logic signed [2*WIDTH-1:0] prod;
    logic tick;

    assign tick   = i_enable && cnt == TLAST;
    assign o_busy = state != IDLE;
    assign o_ch   = ch;

    // Operand selection for the single shared multiplier, plus per-channel error terms
    always_comb begin
        sp_c      = i_setpoint[ch*WIDTH +: WIDTH];
        pv_c      = i_curpoint[ch*WIDTH +: WIDTH];
        err_c     = sat(AW'(sp_c) - AW'(pv_c));
        integ_n_c = sat(AW'(integ[ch]) + AW'(err_c));
        derr_c    = sat(AW'(err_r) - AW'(prev_err[ch]));
        op_a      = state == MUL_P ? err_r : state == MUL_I ? integ_n_r : derr_c;
        op_b      = state == MUL_P ? KP : state == MUL_I ? KI : KD;
        prod      = op_a * op_b;
    end

    // Sample tick divider, parked at zero while disabled
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            cnt <= '0;
        else
            cnt <= (!i_enable || cnt == TLAST) ? '0 : cnt + TW'(1);
    end

    // Frame sequencer and MAC: five cycles per channel, outputs written one channel at a time
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= IDLE;
            ch        <= '0;
            acc       <= '0;
            err_r     <= '0;
            integ_n_r <= '0;
            o_out     <= '0;
            o_valid   <= 1'b0;
            o_overrun <= 1'b0;
            for (int i = 0; i < NCH; i++)
                prev_err[i] <= '0;
        end else begin
            o_valid <= state == WRITE && ch == LAST;
            if (tick && state != IDLE)
                o_overrun <= 1'b1;
            case (state)
                IDLE: if (tick) state <= FETCH;
                FETCH: begin
                    err_r     <= err_c;
                    integ_n_r <= integ_n_c;
                    acc       <= '0;
                    state     <= MUL_P;
                end
                MUL_P, MUL_I, MUL_D: begin
                    acc   <= acc + AW'(prod);
                    state <= state + 3'd1;
                end
                WRITE: begin
                    o_out[ch*WIDTH +: WIDTH] <= sat(acc >>> QBITS);
                    prev_err[ch]             <= err_r;
                    state                    <= ch == LAST ? IDLE : FETCH;
                    ch                       <= ch == LAST ? '0 : ch + CW'(1);
                end
                default: begin
                    state <= IDLE;
                    ch    <= '0;
                end
            endcase
        end
    end

    // Integrators: a clear request wins over the end-of-channel update
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NCH; i++)
                integ[i] <= '0;
        end else begin
            for (int i = 0; i < NCH; i++)
                if (i_clear_int)
                    integ[i] <= '0;
                else if (state == WRITE && ch == CW'(i))
                    integ[i] <= integ_n_r;
        end
    end
endmodule

// File: tb/tb_pid_frame_scheduler.sv
// tb_pid_frame_scheduler: vector table, corner sequences and randomized frames against a PID model
module tb_pid_frame_scheduler;
    typedef struct {int sp0; int pv0; int sp1; int pv1; int o0; int o1;} vec_t;
    localparam int KP = 256;
    localparam int KI = 128;
    localparam int KD = 256;

    logic clk = 0, rst = 1, en = 0, clr = 0, rst_o = 1, en_o = 0;
    logic [31:0] sp_bus = '0, pv_bus = '0, out_a, out_b;
    logic valid_a, busy_a, ch_a, ovr_a, valid_b, busy_b, ch_b, ovr_b;
    int n_chk = 0, n_err = 0;
    int sp_v[2], pv_v[2], integ_m[2], prev_m[2], out_m[2];
    vec_t tbl[4];

    always #5 clk = ~clk;

    pid_frame_scheduler #(.NCH(2), .WIDTH(16), .QBITS(8), .KP(16'sh0100), .KI(16'sh0080),
                          .KD(16'sh0100), .TICK_DIV(20)) dut (
        .i_clk(clk), .i_rst(rst), .i_enable(en), .i_clear_int(clr),
        .i_setpoint(sp_bus), .i_curpoint(pv_bus), .o_out(out_a), .o_valid(valid_a),
        .o_busy(busy_a), .o_ch(ch_a), .o_overrun(ovr_a));

    pid_frame_scheduler #(.NCH(2), .WIDTH(16), .QBITS(8), .KP(16'sh0100), .KI(16'sh0000),
                          .KD(16'sh0000), .TICK_DIV(4)) dut_o (
        .i_clk(clk), .i_rst(rst_o), .i_enable(en_o), .i_clear_int(1'b0),
        .i_setpoint(sp_bus), .i_curpoint(pv_bus), .o_out(out_b), .o_valid(valid_b),
        .o_busy(busy_b), .o_ch(ch_b), .o_overrun(ovr_b));

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int sat16(input longint x);
        return x > 32767 ? 32767 : x < -32768 ? -32768 : int'(x);
    endfunction

    function automatic int s16(input logic [15:0] v);
        logic signed [15:0] t;
        t = v;
        return t;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            integ_m[c] = 0;
            prev_m[c]  = 0;
            out_m[c]   = 0;
        end
    endtask

    task automatic model_frame();
        for (int c = 0; c < 2; c++) begin
            int e, in, d;
            longint acc;
            e   = sat16(longint'(sp_v[c]) - pv_v[c]);
            in  = sat16(longint'(integ_m[c]) + e);
            d   = sat16(longint'(e) - prev_m[c]);
            acc = longint'(e) * KP + longint'(in) * KI + longint'(d) * KD;
            out_m[c]   = sat16(acc >>> 8);
            prev_m[c]  = e;
            integ_m[c] = in;
        end
    endtask

    task automatic drive();
        sp_bus = {sp_v[1][15:0], sp_v[0][15:0]};
        pv_bus = {pv_v[1][15:0], pv_v[0][15:0]};
    endtask

    task automatic run_frame(input bit glitch, input bit drop_en);
        int k;
        @(negedge clk);
        drive();
        k = 0;
        while (busy_a !== 1'b1 && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk("busy_rise", busy_a, 1);
        if (busy_a !== 1'b1) return;
        model_frame();
        for (int c = 1; c <= 10; c++) begin
            chk("busy_in_frame", busy_a, 1);
            chk("ch_in_frame", ch_a, (c - 1) / 5);
            chk("no_early_valid", valid_a, 0);
            if (c == 2 && drop_en) en = 0;
            if (c == 9 && glitch) begin
                sp_bus = $urandom;
                pv_bus = $urandom;
            end
            @(negedge clk);
        end
        chk("valid_latency", valid_a, 1);
        chk("busy_after_frame", busy_a, 0);
        chk("out0_model", s16(out_a[15:0]), out_m[0]);
        chk("out1_model", s16(out_a[31:16]), out_m[1]);
        @(negedge clk);
        chk("valid_pulse", valid_a, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k, seen;
        tbl[0] = '{100, 40, -5, 5, 150, -25};
        tbl[1] = '{100, 40, -5, 5, 120, -20};
        tbl[2] = '{10, 0, 0, 3, 25, -8};
        tbl[3] = '{32767, -32768, -32768, 32767, 32767, -32768};

        repeat (2) @(negedge clk);
        chk("rst_out", int'(out_a), 0);
        chk("rst_valid", valid_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_ch", ch_a, 0);
        chk("rst_ovr", ovr_a, 0);
        rst = 0;
        en  = 1;
        model_reset();

        foreach (tbl[i]) begin
            sp_v = '{tbl[i].sp0, tbl[i].sp1};
            pv_v = '{tbl[i].pv0, tbl[i].pv1};
            run_frame(i == 2, 1'b0);
            chk("tbl_out0", s16(out_a[15:0]), tbl[i].o0);
            chk("tbl_out1", s16(out_a[31:16]), tbl[i].o1);
        end

        clr = 1;
        @(negedge clk);
        clr = 0;
        integ_m = '{0, 0};
        sp_v = '{100, -5};
        pv_v = '{40, 5};
        run_frame(1'b0, 1'b0);

        run_frame(1'b0, 1'b1);
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (busy_a) seen = 1;
        end
        chk("en_low_idle", seen, 0);
        en = 1;

        sp_v = '{7, 300};
        pv_v = '{2, -100};
        @(negedge clk);
        drive();
        k = 0;
        while (busy_a !== 1'b1 && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk("abort_busy_rise", busy_a, 1);
        repeat (7) @(negedge clk);
        chk("abort_ch1", ch_a, 1);
        rst = 1;
        #1;
        chk("abort_out", int'(out_a), 0);
        chk("abort_valid", valid_a, 0);
        chk("abort_busy", busy_a, 0);
        chk("abort_ch", ch_a, 0);
        @(negedge clk);
        rst = 0;
        model_reset();
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (valid_a) seen = 1;
        end
        chk("abort_no_valid", seen, 0);
        sp_v = '{100, -5};
        pv_v = '{40, 5};
        run_frame(1'b0, 1'b0);
        chk("post_rst_d_out0", s16(out_a[15:0]), 150);
        chk("post_rst_d_out1", s16(out_a[31:16]), -25);

        for (int f = 0; f < 40; f++) begin
            for (int c = 0; c < 2; c++) begin
                logic [15:0] r;
                if ($urandom_range(3) == 0) begin
                    r = 16'($urandom);
                    sp_v[c] = s16(r);
                    r = 16'($urandom);
                    pv_v[c] = s16(r);
                end else begin
                    sp_v[c] = int'($urandom_range(400)) - 200;
                    pv_v[c] = int'($urandom_range(400)) - 200;
                end
            end
            if ($urandom_range(5) == 0) begin
                clr = 1;
                @(negedge clk);
                clr = 0;
                integ_m = '{0, 0};
            end
            run_frame(1'($urandom_range(1)), 1'b0);
        end

        en = 0;
        sp_v = '{100, -5};
        pv_v = '{40, 5};
        @(negedge clk);
        drive();
        rst_o = 0;
        @(negedge clk);
        chk("ovr_init", ovr_b, 0);
        en_o = 1;
        k = 0;
        while (ovr_b !== 1'b1 && k < 30) begin
            @(negedge clk);
            k++;
        end
        chk("ovr_rise", ovr_b, 1);
        chk("ovr_while_busy", busy_b, 1);
        chk("ovr_no_valid_yet", valid_b, 0);
        k = 0;
        while (valid_b !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("ovr_valid", valid_b, 1);
        chk("ovr_out0", s16(out_b[15:0]), 60);
        chk("ovr_out1", s16(out_b[31:16]), -10);
        k = 0;
        while (busy_b !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        k = 1;
        while (valid_b !== 1'b1 && k < 30) begin
            @(negedge clk);
            k++;
        end
        chk("ovr_frame_len", k, 11);
        en_o = 0;
        repeat (20) @(negedge clk);
        chk("ovr_sticky", ovr_b, 1);
        rst_o = 1;
        #1;
        chk("ovr_cleared_by_rst", ovr_b, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
